// File: rtl/port_arbiter_pkg.sv
// Shared definitions for the four-port round-robin arbiter and its output queue.
package port_arbiter_pkg;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_S = 2'd1,
        PORT_E = 2'd2,
        PORT_W = 2'd3
    } port_e;

    localparam int NUM_PORTS  = 4;
    localparam int FLIT_W_DEF = 7;
    localparam int DEPTH_DEF  = 4;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/port_arbiter_if.sv
// Request/grant bundle for the four input ports plus the downstream flit channel.
interface port_arbiter_if #(
    parameter  int FLIT_W = port_arbiter_pkg::FLIT_W_DEF,
    parameter  int DEPTH  = port_arbiter_pkg::DEPTH_DEF,
    localparam int CNT_W  = $clog2(DEPTH + 1)
);
    logic              nsig, ssig, esig, wsig;
    logic [FLIT_W-1:0] ninc, sinc, einc, winc;
    logic              ngnt, sgnt, egnt, wgnt;
    logic [FLIT_W-1:0] oflit;
    logic              ovalid;
    logic              ordy;
    logic [1:0]        oport;
    logic [CNT_W-1:0]  count;

    // Requesters and the downstream consumer.
    modport master (
        output nsig, ssig, esig, wsig,
        output ninc, sinc, einc, winc,
        output ordy,
        input  ngnt, sgnt, egnt, wgnt,
        input  oflit, ovalid, oport, count
    );

    // The arbiter itself.
    modport slave (
        input  nsig, ssig, esig, wsig,
        input  ninc, sinc, einc, winc,
        input  ordy,
        output ngnt, sgnt, egnt, wgnt,
        output oflit, ovalid, oport, count
    );
endinterface

// File: rtl/port_arbiter_flit_fifo.sv
// Output queue: DEPTH-entry circular buffer with a registered head that is zero when empty.
module flit_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ordy,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
    logic [IDX_W-1:0] wr_idx_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] head_reg;
    logic             pop;

    assign pop = (count_reg != '0) && ordy;

    always_comb begin
        rd_idx_next = pop ? rd_idx_reg + IDX_W'(1) : rd_idx_reg;
        count_next  = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !srst) begin
            mem[wr_idx_reg] <= wdata;
        end
    end

    // Head is re-read from the next read index each edge; a flit landing in that very
    // slot on the same edge is forwarded so a fresh push is visible one cycle later.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_idx_reg <= '0;
            wr_idx_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            rd_idx_reg <= rd_idx_next;
            count_reg  <= count_next;
            if (push) begin
                wr_idx_reg <= wr_idx_reg + IDX_W'(1);
            end
            if (count_next == '0) begin
                head_reg <= '0;
            end else if (push && (wr_idx_reg == rd_idx_next)) begin
                head_reg <= wdata;
            end else begin
                head_reg <= mem[rd_idx_next];
            end
        end
    end

    assign head  = head_reg;
    assign valid = (count_reg != '0);
    assign count = count_reg;
endmodule

// File: rtl/port_arbiter.sv
// Four-port round-robin arbiter feeding a small output queue; grants are combinational.
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] rot_req;
    logic [NUM_PORTS-1:0] gnt;
    logic [FLIT_W-1:0]    inc [NUM_PORTS];
    logic [1:0]           ptr_reg, ptr_next;
    logic [1:0]           offset;
    logic [1:0]           gidx;
    logic                 found;
    logic                 can_push;
    logic                 grant_any;
    logic [FLIT_W+1:0]    fifo_head;
    logic                 fifo_valid;
    logic [CNT_W-1:0]     fifo_count;

    assign req    = {bus.wsig, bus.esig, bus.ssig, bus.nsig};
    assign inc[0] = bus.ninc;
    assign inc[1] = bus.sinc;
    assign inc[2] = bus.einc;
    assign inc[3] = bus.winc;

    // Rotate requests so bit 0 is the port the pointer currently favours.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
            assign rot_req[gi] = req[2'(ptr_reg + 2'(gi))];
        end
    endgenerate

    always_comb begin
        found  = 1'b0;
        offset = 2'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && rot_req[k]) begin
                found  = 1'b1;
                offset = 2'(k);
            end
        end
    end

    // A pop on the same edge does not open a slot; reset suppresses every grant.
    assign gidx      = ptr_reg + offset;
    assign can_push  = !rst && (fifo_count < CNT_W'(DEPTH));
    assign grant_any = found && can_push;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_gnt
            assign gnt[gi] = grant_any && (gidx == 2'(gi));
        end
    endgenerate

    assign ptr_next = grant_any ? next_port(gidx) : ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= PORT_N;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    flit_fifo #(
        .WIDTH(FLIT_W + 2),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .srst (rst),
        .push (grant_any),
        .wdata({gidx, inc[gidx]}),
        .ordy (bus.ordy),
        .head (fifo_head),
        .valid(fifo_valid),
        .count(fifo_count)
    );

    assign bus.ngnt   = gnt[0];
    assign bus.sgnt   = gnt[1];
    assign bus.egnt   = gnt[2];
    assign bus.wgnt   = gnt[3];
    assign bus.oflit  = fifo_head[FLIT_W-1:0];
    assign bus.oport  = fifo_head[FLIT_W+1:FLIT_W];
    assign bus.ovalid = fifo_valid;
    assign bus.count  = fifo_count;
endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: reset, single flit, round-robin, full queue, push+pop, mid-run reset.
module tb_port_arbiter;
    import port_arbiter_pkg::*;

    localparam int FLIT_W = 7;
    localparam int DEPTH  = 4;

    localparam logic [6:0] NV = 7'h11;
    localparam logic [6:0] SV = 7'h22;
    localparam logic [6:0] EV = 7'h33;
    localparam logic [6:0] WV = 7'h44;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gnt;
    logic [6:0] vals [4];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    port_arbiter_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) bus ();

    port_arbiter #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    assign gnt = {bus.wgnt, bus.egnt, bus.sgnt, bus.ngnt};

    task automatic set_req(input logic [3:0] r);
        bus.nsig = r[0];
        bus.ssig = r[1];
        bus.esig = r[2];
        bus.wsig = r[3];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(4'hF);
        bus.ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            n_cmp++;
            if (gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL rst_gnt cyc%0d: got %b want 0000", i, gnt);
            end
        end
        n_cmp++;
        if (bus.count !== 3'd0 || bus.ovalid !== 1'b0 || bus.oflit !== 7'h00 || bus.oport !== 2'd0) begin
            n_err++;
            $display("FAIL rst_state: got count=%0d ovalid=%b oflit=%h oport=%0d want 0/0/00/0",
                     bus.count, bus.ovalid, bus.oflit, bus.oport);
        end
        rst = 1'b0;
        set_req(4'h0);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            n_cmp++;
            if (bus.ovalid !== 1'b0 || bus.count !== 3'd0 || gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL idle cyc%0d: got ovalid=%b count=%0d gnt=%b want 0/0/0000",
                         i, bus.ovalid, bus.count, gnt);
            end
        end
        $display("test_reset done: %0d compared", n_cmp);
    endtask

    task automatic test_single();
        bus.nsig = 1'b1;
        bus.ninc = 7'h55;
        #1;
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL single_gnt: got %b want 0001", gnt);
        end
        next_cycle();
        bus.nsig = 1'b0;
        bus.ninc = NV;
        n_cmp++;
        if (bus.oflit !== 7'h55 || bus.oport !== 2'd0 || bus.ovalid !== 1'b1 || bus.count !== 3'd1) begin
            n_err++;
            $display("FAIL single_out: got oflit=%h oport=%0d ovalid=%b count=%0d want 55/0/1/1",
                     bus.oflit, bus.oport, bus.ovalid, bus.count);
        end
        next_cycle();
        n_cmp++;
        if (bus.count !== 3'd0 || bus.ovalid !== 1'b0 || bus.oflit !== 7'h00) begin
            n_err++;
            $display("FAIL single_pop: got count=%0d ovalid=%b oflit=%h want 0/0/00",
                     bus.count, bus.ovalid, bus.oflit);
        end
        $display("test_single done: %0d compared", n_cmp);
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_req(4'hF);
            #1;
            n_cmp++;
            if (gnt !== (4'b0001 << (c % 4))) begin
                n_err++;
                $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, 4'b0001 << (c % 4));
            end
            if (c >= 1) begin
                n_cmp++;
                if (bus.oport !== 2'((c - 1) % 4) || bus.oflit !== vals[(c - 1) % 4] || bus.count !== 3'd1) begin
                    n_err++;
                    $display("FAIL rr_out c%0d: got oport=%0d oflit=%h count=%0d want %0d/%h/1",
                             c, bus.oport, bus.oflit, bus.count, (c - 1) % 4, vals[(c - 1) % 4]);
                end
            end
            next_cycle();
        end
        set_req(4'h0);
        n_cmp++;
        if (bus.oport !== 2'd3 || bus.oflit !== WV) begin
            n_err++;
            $display("FAIL rr_last: got oport=%0d oflit=%h want 3/%h", bus.oport, bus.oflit, WV);
        end
        next_cycle();
        n_cmp++;
        if (bus.count !== 3'd0) begin
            n_err++;
            $display("FAIL rr_drain: got count=%0d want 0", bus.count);
        end
        $display("test_round_robin done: %0d compared", n_cmp);
    endtask

    task automatic test_full();
        bus.ordy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_req(4'hF);
            #1;
            n_cmp++;
            if (gnt !== (4'b0001 << c)) begin
                n_err++;
                $display("FAIL fill_gnt c%0d: got %b want %b", c, gnt, 4'b0001 << c);
            end
            next_cycle();
            n_cmp++;
            if (bus.count !== 3'(c + 1)) begin
                n_err++;
                $display("FAIL fill_count c%0d: got %0d want %0d", c, bus.count, c + 1);
            end
        end
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL full_gnt: got %b want 0000", gnt);
        end
        next_cycle();
        n_cmp++;
        if (bus.count !== 3'd4 || gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL full_hold: got count=%0d gnt=%b want 4/0000", bus.count, gnt);
        end
        bus.ordy = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL full_pop_gnt: got %b want 0000", gnt);
        end
        next_cycle();
        bus.ordy = 1'b0;
        #1;
        n_cmp++;
        if (bus.count !== 3'd3 || bus.oport !== 2'd1 || bus.oflit !== SV || gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL after_pop: got count=%0d oport=%0d oflit=%h gnt=%b want 3/1/%h/0001",
                     bus.count, bus.oport, bus.oflit, gnt, SV);
        end
        next_cycle();
        n_cmp++;
        if (bus.count !== 3'd4 || gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL refill: got count=%0d gnt=%b want 4/0000", bus.count, gnt);
        end
        $display("test_full done: %0d compared", n_cmp);
    endtask

    task automatic test_push_pop();
        set_req(4'h0);
        bus.ordy = 1'b1;
        next_cycle();
        next_cycle();
        n_cmp++;
        if (bus.count !== 3'd2 || bus.oport !== 2'd3 || bus.oflit !== WV) begin
            n_err++;
            $display("FAIL pp_pre: got count=%0d oport=%0d oflit=%h want 2/3/%h",
                     bus.count, bus.oport, bus.oflit, WV);
        end
        bus.sinc = 7'h3C;
        set_req(4'b0010);
        #1;
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL pp_gnt: got %b want 0010", gnt);
        end
        next_cycle();
        set_req(4'h0);
        bus.ordy = 1'b0;
        bus.sinc = SV;
        n_cmp++;
        if (bus.count !== 3'd2 || bus.oport !== 2'd0 || bus.oflit !== NV) begin
            n_err++;
            $display("FAIL pp_post: got count=%0d oport=%0d oflit=%h want 2/0/%h",
                     bus.count, bus.oport, bus.oflit, NV);
        end
        $display("test_push_pop done: %0d compared", n_cmp);
    endtask

    task automatic test_reset_mid();
        set_req(4'hF);
        #1;
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_gnt: got %b want 0100", gnt);
        end
        next_cycle();
        n_cmp++;
        if (bus.count !== 3'd3) begin
            n_err++;
            $display("FAIL mid_count: got %0d want 3", bus.count);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_rst_gnt: got %b want 0000", gnt);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.count !== 3'd0 || bus.ovalid !== 1'b0 || bus.oflit !== 7'h00 ||
            bus.oport !== 2'd0 || gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL mid_post: got count=%0d ovalid=%b oflit=%h oport=%0d gnt=%b want 0/0/00/0/0001",
                     bus.count, bus.ovalid, bus.oflit, bus.oport, gnt);
        end
        next_cycle();
        set_req(4'h0);
        n_cmp++;
        if (bus.count !== 3'd1 || bus.oport !== 2'd0 || bus.oflit !== NV) begin
            n_err++;
            $display("FAIL mid_first: got count=%0d oport=%0d oflit=%h want 1/0/%h",
                     bus.count, bus.oport, bus.oflit, NV);
        end
        $display("test_reset_mid done: %0d compared", n_cmp);
    endtask

    initial begin
        vals[0] = NV;
        vals[1] = SV;
        vals[2] = EV;
        vals[3] = WV;
        rst      = 1'b1;
        bus.ordy = 1'b0;
        bus.ninc = NV;
        bus.sinc = SV;
        bus.einc = EV;
        bus.winc = WV;
        set_req(4'h0);
        next_cycle();
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
